// File: rtl/aud_rec_writer_if.sv
// rtl/aud_rec_writer_if.sv - SRAM write-port bundle for the I2S recorder
//
// Purpose: groups the recorder's SRAM write bus so it can be passed as one
// port. The recorder drives it (master); the SRAM arbiter consumes it (slave).
// Signals:
//   addr  P_ADDR_W  word write address
//   data  16        sample to write
//   we    1         one-cycle write strobe, active high
interface aud_rec_writer_if #(
  parameter int P_ADDR_W = 20
);
  logic [P_ADDR_W-1:0] addr;
  logic [15:0]         data;
  logic                we;

  modport master (output addr, output data, output we);
  modport slave  (input  addr, input  data, input  we);
endinterface

// File: rtl/aud_rec_writer.sv
// rtl/aud_rec_writer.sv - I2S left-channel recorder writing sequential SRAM words
//
// Purpose: deserialises the left-channel 16-bit sample of the codec ADC I2S
// stream (one-bit delay after the LRCK falling edge, MSB first), writes every
// completed sample to SRAM at sequential addresses and reports the word count.
// Clocked by the codec bit clock; reset is synchronous, active low.
// Optional feature macro: REC_PEAK_EN adds o_peak (max |sample| since i_start).
// Ports:
//   i_clk        codec BCLK, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      pulse: start at address 0, or resume when paused
//   i_pause      pulse: suspend, keep address (partial word dropped)
//   i_stop       pulse: end recording
//   i_lrc        ADCLRCK, low = left channel
//   i_adc_data   ADCDAT serial bit
//   sram         SRAM write bus (addr/data/we), master side
//   o_final_addr words written (one past last written address)
//   o_busy       high while waiting, shifting or writing
//   o_full       sticky: last address has been written
//   o_peak       (REC_PEAK_EN only) peak absolute sample value
module aud_rec_writer #(
  parameter int                  P_ADDR_W   = 20,
  parameter logic [P_ADDR_W-1:0] P_ADDR_MAX = 20'hFFFFF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_lrc,
  input  logic                i_adc_data,
  aud_rec_writer_if.master    sram,
  output logic [P_ADDR_W-1:0] o_final_addr,
  output logic                o_busy,
`ifdef REC_PEAK_EN
  output logic [15:0]         o_peak,
`endif
  output logic                o_full
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SHIFT  = 3'd2,
    S_WRITE  = 3'd3,
    S_PAUSED = 3'd4
  } state_t;

  localparam logic [P_ADDR_W-1:0] LP_ONE = {{(P_ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic                r_lrc_prev;
  logic [3:0]          r_cnt;
  logic [15:0]         r_shift;
  logic [P_ADDR_W-1:0] r_addr;
  logic [P_ADDR_W-1:0] r_final;
  logic                r_full;
  logic                w_frame;
  logic                w_restart;

  // Left frame begins on the LRCK falling edge.
  assign w_frame   = r_lrc_prev & ~i_lrc;
  // A start that is not overridden by stop and is not a resume rewinds to 0.
  assign w_restart = i_start & ~i_stop & (r_state != S_PAUSED);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: stop > start > pause
  always_comb begin
    w_next = r_state;
    if (i_stop) begin
      w_next = S_IDLE;
    end else if (i_start) begin
      w_next = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (i_pause)      w_next = S_PAUSED;
          else if (w_frame) w_next = S_SHIFT;
        end
        S_SHIFT: begin
          // A new frame edge mid-word restarts capture for that frame.
          if (i_pause)            w_next = S_PAUSED;
          else if (w_frame)       w_next = S_SHIFT;
          else if (r_cnt == 4'd15) w_next = S_WRITE;
        end
        S_WRITE: begin
          // The write always completes; pause takes effect afterwards.
          if (r_addr == P_ADDR_MAX) w_next = S_IDLE;
          else if (i_pause)         w_next = S_PAUSED;
          else                      w_next = S_WAIT;
        end
        default: w_next = r_state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    sram.we      = (r_state == S_WRITE);
    sram.addr    = r_addr;
    sram.data    = r_shift;
    o_final_addr = r_final;
    o_full       = r_full;
    o_busy       = (r_state == S_WAIT) || (r_state == S_SHIFT) || (r_state == S_WRITE);
  end

  // Deserialiser. The bit sampled on the frame-edge cycle is the I2S delay
  // slot and is skipped; the following 16 bits are shifted in MSB first.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lrc_prev <= 1'b1;
      r_cnt      <= 4'd0;
      r_shift    <= 16'd0;
    end else begin
      r_lrc_prev <= i_lrc;
      if (w_next == S_SHIFT && (r_state != S_SHIFT || w_frame)) begin
        r_cnt <= 4'd0;
      end else if (r_state == S_SHIFT) begin
        r_shift <= {r_shift[14:0], i_adc_data};
        r_cnt   <= r_cnt + 4'd1;
      end
    end
  end

  // Address / count bookkeeping. At the last address the pointer stays put
  // and the count wraps to P_ADDR_MAX+1 truncated; o_full disambiguates.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_final <= '0;
      r_full  <= 1'b0;
    end else if (w_restart) begin
      r_addr  <= '0;
      r_final <= '0;
      r_full  <= 1'b0;
    end else if (r_state == S_WRITE) begin
      r_final <= r_addr + LP_ONE;
      if (r_addr == P_ADDR_MAX) r_full <= 1'b1;
      else                      r_addr <= r_addr + LP_ONE;
    end
  end

`ifdef REC_PEAK_EN
  logic [15:0] r_peak;
  logic [15:0] w_abs;

  // -32768 has no positive 16-bit counterpart, so it saturates.
  always_comb begin
    w_abs = r_shift;
    if (r_shift[15]) w_abs = (r_shift == 16'h8000) ? 16'h7FFF : (~r_shift + 16'd1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                              r_peak <= 16'd0;
    else if (i_start && !i_stop)               r_peak <= 16'd0;
    else if (r_state == S_WRITE && w_abs > r_peak) r_peak <= w_abs;
  end

  assign o_peak = r_peak;
`endif

endmodule
